sci_sync_link: RTL and testbench

Clocked-synchronous serial endpoint that sits directly downstream of the SH7034 SCI channel when the SCI runs in clocked-synchronous mode (SMR.CA=1, internal clock output). It consumes the SCI's SCKO/TXD pair, deserialises received bytes into an RX FIFO, and serialises bytes from a TX FIFO back onto the SCI's RXD line. The host side is a pair of valid/ready byte streams plus sticky error flags, for attachment to the device model that the SCI talks to.

---
 rtl/sci_sync_link_if.sv | 29 ++
 rtl/sci_sync_link.sv | 183 ++++++++++++++++++
 tb/tb_sci_sync_link.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sci_sync_link_if.sv
// Host-side byte streams and status of sci_sync_link: RX/TX valid/ready pairs,
// FIFO occupancy and sticky error flags.
interface sci_sync_link_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [7:0]    RX_DATA;
    logic          RX_VALID;
    logic          RX_READY;
    logic [7:0]    TX_DATA;
    logic          TX_VALID;
    logic          TX_READY;
    logic [LW-1:0] RX_LEVEL;
    logic [LW-1:0] TX_LEVEL;
    logic          RX_OVF;
    logic          TX_UNF;
    logic          CLR_ERR;

    modport master (
        output RX_READY, TX_DATA, TX_VALID, CLR_ERR,
        input  RX_DATA, RX_VALID, TX_READY, RX_LEVEL, TX_LEVEL, RX_OVF, TX_UNF
    );

    modport slave (
        input  RX_READY, TX_DATA, TX_VALID, CLR_ERR,
        output RX_DATA, RX_VALID, TX_READY, RX_LEVEL, TX_LEVEL, RX_OVF, TX_UNF
    );
endinterface

// File: rtl/sci_sync_link.sv
// Clocked-synchronous serial endpoint for the SH7034 SCI: deserialises SDI into an
// RX FIFO and serialises a TX FIFO onto SDO, all state advancing on CE.
module sci_sync_link #(
    parameter int DEPTH   = 4,
    parameter int IDLE_TO = 1024
) (
    input  logic CLK,
    input  logic RST,
    input  logic CE,
    input  logic SCK,
    input  logic SDI,
    output logic SDO,
    sci_sync_link_if.slave host
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(IDLE_TO + 1);

    logic          sck_old_q, sck_old_d;
    logic [2:0]    bcnt_q,    bcnt_d;
    logic [7:0]    rsr_q,     rsr_d;
    logic [7:0]    tsr_q,     tsr_d;
    logic          sdo_q,     sdo_d;
    logic [TW-1:0] timer_q,   timer_d;
    logic [7:0]    rx_mem_q [DEPTH];
    logic [7:0]    rx_mem_d [DEPTH];
    logic [7:0]    tx_mem_q [DEPTH];
    logic [7:0]    tx_mem_d [DEPTH];
    logic [PW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic          rx_ovf_q, rx_ovf_d;
    logic          tx_unf_q, tx_unf_d;

    logic       rise_s, fall_s, timeout_s;
    logic       rx_empty_s, rx_full_s, tx_empty_s, tx_full_s;
    logic       rx_pop_s, rx_push_s, rx_drop_s, byte_done_s;
    logic       tx_push_s, tx_pop_s, tx_starve_s, slot_start_s;
    logic [7:0] rx_byte_s, load_byte_s;

    assign rise_s = CE &  SCK & ~sck_old_q;
    assign fall_s = CE & ~SCK &  sck_old_q;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign rx_empty_s = (rx_wp_q == rx_rp_q);
    assign rx_full_s  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
    assign tx_empty_s = (tx_wp_q == tx_rp_q);
    assign tx_full_s  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);

    assign byte_done_s = rise_s && (bcnt_q == 3'd7);
    assign rx_byte_s   = {SDI, rsr_q[7:1]};
    assign rx_pop_s    = CE & ~rx_empty_s & host.RX_READY;
    assign rx_push_s   = byte_done_s & (~rx_full_s | rx_pop_s);
    assign rx_drop_s   = byte_done_s & rx_full_s & ~rx_pop_s;

    assign slot_start_s = fall_s && (bcnt_q == 3'd0);
    assign tx_push_s    = CE & host.TX_VALID & ~tx_full_s;
    assign tx_pop_s     = slot_start_s & ~tx_empty_s;
    assign tx_starve_s  = slot_start_s & tx_empty_s;
    assign load_byte_s  = tx_empty_s ? 8'hFF : tx_mem_q[tx_rp_q[AW-1:0]];

    assign timeout_s = CE & SCK & (bcnt_q != 3'd0) & (timer_q == TW'(IDLE_TO - 1));

    // Next-state logic for the serial engine, both FIFOs and the error flags.
    always_comb begin
        sck_old_d = sck_old_q;
        bcnt_d    = bcnt_q;
        rsr_d     = rsr_q;
        tsr_d     = tsr_q;
        sdo_d     = sdo_q;
        timer_d   = timer_q;
        rx_mem_d  = rx_mem_q;
        tx_mem_d  = tx_mem_q;
        rx_wp_d   = rx_wp_q;
        rx_rp_d   = rx_rp_q;
        tx_wp_d   = tx_wp_q;
        tx_rp_d   = tx_rp_q;
        rx_ovf_d  = rx_ovf_q;
        tx_unf_d  = tx_unf_q;

        if (CE) begin
            sck_old_d = SCK;
            if (!SCK || (bcnt_q == 3'd0) || timeout_s) begin
                timer_d = '0;
            end else begin
                timer_d = timer_q + 1'b1;
            end
            rx_ovf_d = (rx_ovf_q & ~host.CLR_ERR) | rx_drop_s;
            tx_unf_d = (tx_unf_q & ~host.CLR_ERR) | tx_starve_s;
        end else begin
            sck_old_d = sck_old_q;
        end

        // A stalled partial byte is abandoned so the next byte starts aligned.
        if (rise_s) begin
            rsr_d  = rx_byte_s;
            bcnt_d = bcnt_q + 3'd1;
        end else if (timeout_s) begin
            bcnt_d = 3'd0;
            rsr_d  = 8'h00;
            tsr_d  = 8'h00;
        end else begin
            bcnt_d = bcnt_q;
        end

        if (slot_start_s) begin
            sdo_d = load_byte_s[0];
            tsr_d = {1'b0, load_byte_s[7:1]};
        end else if (fall_s) begin
            sdo_d = tsr_q[0];
            tsr_d = {1'b0, tsr_q[7:1]};
        end else begin
            sdo_d = sdo_q;
        end

        if (rx_push_s) begin
            rx_mem_d[rx_wp_q[AW-1:0]] = rx_byte_s;
            rx_wp_d = rx_wp_q + 1'b1;
        end else begin
            rx_wp_d = rx_wp_q;
        end
        if (rx_pop_s) begin
            rx_rp_d = rx_rp_q + 1'b1;
        end else begin
            rx_rp_d = rx_rp_q;
        end

        if (tx_push_s) begin
            tx_mem_d[tx_wp_q[AW-1:0]] = host.TX_DATA;
            tx_wp_d = tx_wp_q + 1'b1;
        end else begin
            tx_wp_d = tx_wp_q;
        end
        if (tx_pop_s) begin
            tx_rp_d = tx_rp_q + 1'b1;
        end else begin
            tx_rp_d = tx_rp_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sck_old_q <= 1'b1;
            bcnt_q    <= 3'd0;
            rsr_q     <= 8'h00;
            tsr_q     <= 8'h00;
            sdo_q     <= 1'b1;
            timer_q   <= '0;
            rx_mem_q  <= '{default: 8'h00};
            tx_mem_q  <= '{default: 8'h00};
            rx_wp_q   <= '0;
            rx_rp_q   <= '0;
            tx_wp_q   <= '0;
            tx_rp_q   <= '0;
            rx_ovf_q  <= 1'b0;
            tx_unf_q  <= 1'b0;
        end else begin
            sck_old_q <= sck_old_d;
            bcnt_q    <= bcnt_d;
            rsr_q     <= rsr_d;
            tsr_q     <= tsr_d;
            sdo_q     <= sdo_d;
            timer_q   <= timer_d;
            rx_mem_q  <= rx_mem_d;
            tx_mem_q  <= tx_mem_d;
            rx_wp_q   <= rx_wp_d;
            rx_rp_q   <= rx_rp_d;
            tx_wp_q   <= tx_wp_d;
            tx_rp_q   <= tx_rp_d;
            rx_ovf_q  <= rx_ovf_d;
            tx_unf_q  <= tx_unf_d;
        end
    end

    assign SDO           = sdo_q;
    assign host.RX_DATA  = rx_mem_q[rx_rp_q[AW-1:0]];
    assign host.RX_VALID = ~rx_empty_s;
    assign host.TX_READY = ~tx_full_s;
    assign host.RX_LEVEL = rx_wp_q - rx_rp_q;
    assign host.TX_LEVEL = tx_wp_q - tx_rp_q;
    assign host.RX_OVF   = rx_ovf_q;
    assign host.TX_UNF   = tx_unf_q;
endmodule

// File: tb/tb_sci_sync_link.sv
// Bench for sci_sync_link: vector table, hand sequences for overflow/resync/reset,
// and random host/serial traffic checked against a byte-level queue model.
module tb_sci_sync_link;
    localparam int DEPTH   = 4;
    localparam int IDLE_TO = 32;

    logic CLK = 1'b0;
    logic RST, CE, SCK, SDI, SDO;

    sci_sync_link_if #(.DEPTH(DEPTH)) hif ();

    sci_sync_link #(.DEPTH(DEPTH), .IDLE_TO(IDLE_TO)) dut (
        .CLK (CLK),
        .RST (RST),
        .CE  (CE),
        .SCK (SCK),
        .SDI (SDI),
        .SDO (SDO),
        .host(hif)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    byte unsigned m_rx[$];
    byte unsigned m_tx[$];
    bit m_ovf, m_unf;

    typedef struct {
        bit         push;
        logic [7:0] txb;
        logic [7:0] sdi;
        logic [7:0] exp_sdo;
        logic [7:0] exp_rx;
        bit         exp_unf;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One CE cycle: CE high for one clock, then low for one clock.
    task automatic step();
        CE = 1'b1;
        @(posedge CLK); #1;
        CE = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".rx_level"}, 32'(hif.RX_LEVEL), m_rx.size());
        check({tag, ".tx_level"}, 32'(hif.TX_LEVEL), m_tx.size());
        check({tag, ".rx_valid"}, 32'(hif.RX_VALID), (m_rx.size() > 0) ? 1 : 0);
        check({tag, ".tx_ready"}, 32'(hif.TX_READY), (m_tx.size() < DEPTH) ? 1 : 0);
        check({tag, ".rx_ovf"}, 32'(hif.RX_OVF), 32'(m_ovf));
        check({tag, ".tx_unf"}, 32'(hif.TX_UNF), 32'(m_unf));
        if (m_rx.size() > 0) check({tag, ".rx_data"}, 32'(hif.RX_DATA), 32'(m_rx[0]));
    endtask

    // SCI-like driver: 2 CE low, 2 CE high per bit; SDO captured just before each rise.
    task automatic send_bits(input logic [7:0] b, input int n, input bit pop_last,
                             output logic [7:0] seen);
        seen = 8'h00;
        for (int i = 0; i < n; i++) begin
            SCK = 1'b0;
            SDI = b[i];
            step();
            step();
            seen[i] = SDO;
            SCK = 1'b1;
            if (pop_last && i == 7) hif.RX_READY = 1'b1;
            step();
            hif.RX_READY = 1'b0;
            step();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit pop_last);
        logic [7:0] exp_sdo, seen;
        if (m_tx.size() > 0) begin
            exp_sdo = m_tx.pop_front();
        end else begin
            exp_sdo = 8'hFF;
            m_unf = 1'b1;
        end
        send_bits(b, 8, pop_last, seen);
        check("sdo_byte", 32'(seen), 32'(exp_sdo));
        if (pop_last && m_rx.size() > 0) void'(m_rx.pop_front());
        if (m_rx.size() < DEPTH) m_rx.push_back(b);
        else m_ovf = 1'b1;
    endtask

    task automatic host_push(input logic [7:0] d);
        check("tx_ready_pre", 32'(hif.TX_READY), (m_tx.size() < DEPTH) ? 1 : 0);
        hif.TX_VALID = 1'b1;
        hif.TX_DATA  = d;
        step();
        hif.TX_VALID = 1'b0;
        if (m_tx.size() < DEPTH) m_tx.push_back(d);
    endtask

    task automatic host_pop();
        if (m_rx.size() > 0) check("pop_data", 32'(hif.RX_DATA), 32'(m_rx[0]));
        hif.RX_READY = 1'b1;
        step();
        hif.RX_READY = 1'b0;
        if (m_rx.size() > 0) void'(m_rx.pop_front());
    endtask

    task automatic clear_err();
        hif.CLR_ERR = 1'b1;
        step();
        hif.CLR_ERR = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        m_rx.delete();
        m_tx.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t tbl[4];
        logic [7:0] seen;

        tbl[0] = '{push: 1'b1, txb: 8'h3C, sdi: 8'hA5, exp_sdo: 8'h3C, exp_rx: 8'hA5, exp_unf: 1'b0};
        tbl[1] = '{push: 1'b0, txb: 8'h00, sdi: 8'h00, exp_sdo: 8'hFF, exp_rx: 8'h00, exp_unf: 1'b1};
        tbl[2] = '{push: 1'b1, txb: 8'h01, sdi: 8'hFF, exp_sdo: 8'h01, exp_rx: 8'hFF, exp_unf: 1'b0};
        tbl[3] = '{push: 1'b1, txb: 8'h80, sdi: 8'h5A, exp_sdo: 8'h80, exp_rx: 8'h5A, exp_unf: 1'b0};

        CE = 1'b0; SCK = 1'b1; SDI = 1'b0; RST = 1'b1;
        hif.RX_READY = 1'b0; hif.TX_VALID = 1'b0; hif.TX_DATA = 8'h00; hif.CLR_ERR = 1'b0;
        do_reset();
        check("reset.sdo", 32'(SDO), 1);
        check_state("reset");

        // Table vectors: loopback, TX pattern and underrun.
        for (int v = 0; v < 4; v++) begin
            clear_err();
            if (tbl[v].push) host_push(tbl[v].txb);
            send_byte(tbl[v].sdi, 1'b0);
            check("vec.rx_valid", 32'(hif.RX_VALID), 1);
            check("vec.rx_level", 32'(hif.RX_LEVEL), 1);
            check("vec.rx_data", 32'(hif.RX_DATA), 32'(tbl[v].exp_rx));
            check("vec.sdo_exp", 32'(tbl[v].exp_sdo), 32'(tbl[v].push ? tbl[v].txb : 8'hFF));
            check("vec.tx_level", 32'(hif.TX_LEVEL), 0);
            check("vec.tx_unf", 32'(hif.TX_UNF), 32'(tbl[v].exp_unf));
            check_state("vec");
            host_pop();
        end
        clear_err();
        check("clr.tx_unf", 32'(hif.TX_UNF), 0);

        // Overflow: five bytes into a four-deep FIFO with no host pops.
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
        check("ovf.level", 32'(hif.RX_LEVEL), 4);
        check("ovf.flag", 32'(hif.RX_OVF), 1);
        for (int i = 1; i <= 4; i++) begin
            check("ovf.order", 32'(hif.RX_DATA), i);
            host_pop();
        end
        check_state("ovf");

        // Full FIFO with a host pop coincident with byte completion: no drop.
        clear_err();
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
        check("nofl.head", 32'(hif.RX_DATA), 1);
        send_byte(8'h05, 1'b1);
        check("nofl.level", 32'(hif.RX_LEVEL), 4);
        check("nofl.flag", 32'(hif.RX_OVF), 0);
        for (int i = 2; i <= 5; i++) begin
            check("nofl.order", 32'(hif.RX_DATA), i);
            host_pop();
        end
        check_state("nofl");

        // Resync: three stray pulses then a long high period.
        clear_err();
        send_bits(8'h07, 3, 1'b0, seen);
        m_unf = 1'b1;
        for (int i = 0; i < IDLE_TO + 4; i++) step();
        send_byte(8'h81, 1'b0);
        check("resync.level", 32'(hif.RX_LEVEL), 1);
        check("resync.data", 32'(hif.RX_DATA), 32'h81);
        check_state("resync");
        host_pop();
        clear_err();

        // Reset mid-byte with both FIFOs and a flag non-idle.
        send_byte(8'h11, 1'b0);
        host_push(8'hC3);
        host_push(8'h3C);
        send_bits(8'hF0, 4, 1'b0, seen);
        check("prerst.tx_level", 32'(hif.TX_LEVEL), 1);
        check("prerst.unf", 32'(hif.TX_UNF), 1);
        do_reset();
        check("rst.sdo", 32'(SDO), 1);
        check("rst.rx_valid", 32'(hif.RX_VALID), 0);
        check("rst.tx_ready", 32'(hif.TX_READY), 1);
        check_state("rst");
        send_byte(8'h5A, 1'b0);
        check("rst.rx_data", 32'(hif.RX_DATA), 32'h5A);
        check_state("postrst");
        host_pop();
        clear_err();

        // Random host and serial traffic against the queue model.
        for (int it = 0; it < 80; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 2) host_push(8'($urandom));
            else if (op <= 4) host_pop();
            else if (op <= 8) send_byte(8'($urandom), ($urandom_range(0, 3) == 0));
            else clear_err();
            check_state("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
